// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher chain: sequencer state encoding and default datapath sizes.
package xor_cipher_pkg;

  localparam int STATE_W      = 3;
  localparam int KEY_SIZE_DEF = 32;
  localparam int MSG_SIZE_DEF = 512;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_KEY  = 3'd1,
    ST_LOAD_MSG  = 3'd2,
    ST_ENCRYPT   = 3'd3,
    ST_SERIALIZE = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } seq_state_e;

  function automatic logic state_busy(input seq_state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR));
  endfunction

endpackage

// File: rtl/xor_seq_watchdog.sv
// Wait-state watchdog for the XOR cipher sequencer: counts enabled cycles, flags expiry at the limit.
module xor_seq_watchdog #(
  parameter int WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Saturates at the limit so a held expiry never wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == limit_i);

endmodule

// File: rtl/xor_cipher_sequencer.sv
// Job-level controller for the XOR cipher datapath: key load, message load, encrypt, serialize, done.
// Optional watchdog on the wait states is built when XOR_SEQ_TIMEOUT_EN is defined.
//
//   state     | meaning
//   IDLE      | no job, waiting for iStart
//   LOAD_KEY  | key deserializer window open, counting iEn bits
//   LOAD_MSG  | message deserializer window open, counting iEn bits
//   ENCRYPT   | waiting for iEncrypt_done
//   SERIALIZE | waiting for iSerial_end
//   DONE      | one-cycle completion pulse, may chain straight into the next job
//   ERROR     | watchdog expired, held until iAbort or iStart
module xor_cipher_sequencer
  import xor_cipher_pkg::*;
#(
  parameter int KEY_SIZE       = KEY_SIZE_DEF,
  parameter int MSG_SIZE       = MSG_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iEn,
  input  logic               iStart,
  input  logic               iReuse_key,
  input  logic               iAbort,
  input  logic               iEncrypt_done,
  input  logic               iSerial_end,
  output logic               oLoad_key,
  output logic               oLoad_msg,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError,
  output logic               oKey_held,
  output logic [STATE_W-1:0] oState
);

  localparam int               CNT_W    = $clog2(MSG_SIZE) + 1;
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_SIZE - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_SIZE - 1);

  seq_state_e       state_q, state_d;
  seq_state_e       start_tgt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_held_q, key_held_d;
  logic             load_key_q, load_msg_q, busy_q, done_q;
  logic             wd_expire;

  assign start_tgt = (iReuse_key && key_held_q) ? ST_LOAD_MSG : ST_LOAD_KEY;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_held_d = key_held_q;
    if (iAbort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      // a key cut off mid-load is unusable
      if (state_q == ST_LOAD_KEY) key_held_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iStart) state_d = start_tgt;
        end
        ST_LOAD_KEY: begin
          if (iEn) begin
            if (cnt_q == KEY_LAST) begin
              cnt_d      = '0;
              key_held_d = 1'b1;
              state_d    = ST_LOAD_MSG;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_LOAD_MSG: begin
          if (iEn) begin
            if (cnt_q == MSG_LAST) begin
              cnt_d   = '0;
              state_d = ST_ENCRYPT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_ENCRYPT: begin
          if (iEncrypt_done) begin
            state_d = iSerial_end ? ST_DONE : ST_SERIALIZE;
          end else if (wd_expire) begin
            state_d = ST_ERROR;
          end
        end
        ST_SERIALIZE: begin
          if (iSerial_end) begin
            state_d = ST_DONE;
          end else if (wd_expire) begin
            state_d = ST_ERROR;
          end
        end
        ST_DONE: begin
          state_d = iStart ? start_tgt : ST_IDLE;
        end
        ST_ERROR: begin
          if (iStart) state_d = start_tgt;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      key_held_q <= 1'b0;
      load_key_q <= 1'b0;
      load_msg_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_held_q <= key_held_d;
      load_key_q <= (state_d == ST_LOAD_KEY);
      load_msg_q <= (state_d == ST_LOAD_MSG);
      busy_q     <= state_busy(state_d);
      done_q     <= (state_d == ST_DONE);
    end
  end

`ifdef XOR_SEQ_TIMEOUT_EN
  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic wd_clr, wd_en, error_q;

  assign wd_en  = (state_q == ST_ENCRYPT) || (state_q == ST_SERIALIZE);
  assign wd_clr = iAbort || (state_d != state_q);

  xor_seq_watchdog #(
    .WIDTH(WD_W)
  ) u_watchdog (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .clr_i   (wd_clr),
    .en_i    (wd_en),
    .limit_i (WD_LIMIT),
    .expire_o(wd_expire)
  );

  // ERROR is only left via iAbort or iStart, so the flag tracks residence in ERROR.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      error_q <= 1'b0;
    end else begin
      error_q <= (state_d == ST_ERROR);
    end
  end

  assign oError = error_q;
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYCLES;
  assign wd_expire      = 1'b0;
  assign oError         = 1'b0;
`endif

  assign oLoad_key = load_key_q;
  assign oLoad_msg = load_msg_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oKey_held = key_held_q;
  assign oState    = state_q;

endmodule

// File: tb/tb_xor_cipher_sequencer.sv
// Scoreboard bench for xor_cipher_sequencer: expected state transitions are queued by the stimulus
// and checked by a monitor whenever oState changes. Build with XOR_SEQ_TIMEOUT_EN for the watchdog case.
module tb_xor_cipher_sequencer;

  logic       iClk = 1'b0;
  logic       iRst, iEn, iStart, iReuse_key, iAbort, iEncrypt_done, iSerial_end;
  logic       oLoad_key, oLoad_msg, oBusy, oDone, oError, oKey_held;
  logic [2:0] oState;

  localparam int S_IDLE = 0, S_LKEY = 1, S_LMSG = 2, S_ENC = 3, S_SER = 4, S_DONE = 5, S_ERR = 6;

  typedef struct {
    int st;
    int dwell;
    int kh;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  int   prev_st;
  int   dwell;

  xor_cipher_sequencer #(
    .KEY_SIZE      (32),
    .MSG_SIZE      (512),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iEn          (iEn),
    .iStart       (iStart),
    .iReuse_key   (iReuse_key),
    .iAbort       (iAbort),
    .iEncrypt_done(iEncrypt_done),
    .iSerial_end  (iSerial_end),
    .oLoad_key    (oLoad_key),
    .oLoad_msg    (oLoad_msg),
    .oBusy        (oBusy),
    .oDone        (oDone),
    .oError       (oError),
    .oKey_held    (oKey_held),
    .oState       (oState)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int st, input int dw, input int kh, input int err);
    exp_t e;
    e.st = st; e.dwell = dw; e.kh = kh; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic wait_state(input int st, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge iClk);
      if (int'(oState) == st) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_state: state=%0d, required %0d within %0d cycles", oState, st, budget);
  endtask

  // Monitor: every change of oState is one DUT response checked against the queue head.
  always @(negedge iClk) begin
    if (mon_en) begin
      if (int'(oState) != prev_st) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_transition: got state %0d, required no transition", oState);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("state", int'(oState), e.st);
          if (e.dwell >= 0) chk("prev_state_cycles", dwell, e.dwell);
          chk("key_held", int'(oKey_held), e.kh);
          chk("error", int'(oError), e.err);
          chk("load_key", int'(oLoad_key), int'(e.st == S_LKEY));
          chk("load_msg", int'(oLoad_msg), int'(e.st == S_LMSG));
          chk("busy", int'(oBusy), int'(e.st >= S_LKEY && e.st <= S_SER));
          chk("done", int'(oDone), int'(e.st == S_DONE));
        end
        prev_st = int'(oState);
        dwell   = 1;
      end else begin
        dwell++;
      end
    end
  end

  initial begin
    iRst = 1'b1; iEn = 1'b0; iStart = 1'b0; iReuse_key = 1'b0;
    iAbort = 1'b0; iEncrypt_done = 1'b0; iSerial_end = 1'b0;
    repeat (3) tick();
    chk("rst_load_key", int'(oLoad_key), 0);
    chk("rst_load_msg", int'(oLoad_msg), 0);
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_done", int'(oDone), 0);
    chk("rst_error", int'(oError), 0);
    chk("rst_key_held", int'(oKey_held), 0);
    chk("rst_state", int'(oState), S_IDLE);
    iRst = 1'b0;
    prev_st = S_IDLE;
    dwell = 0;
    mon_en = 1'b1;
    tick();

    // Full job, iEn held high: 32 key cycles, 512 message cycles.
    push(S_LKEY, -1, 0, 0); push(S_LMSG, 32, 1, 0); push(S_ENC, 512, 1, 0);
    iStart = 1'b1; iReuse_key = 1'b0; iEn = 1'b1;
    tick();
    iStart = 1'b0;
    wait_state(S_ENC, 600);

    // Encrypt done, serial end five cycles later.
    push(S_SER, -1, 1, 0); push(S_DONE, 5, 1, 0); push(S_IDLE, 1, 1, 0);
    iEn = 1'b0; iEncrypt_done = 1'b1;
    tick();
    iEncrypt_done = 1'b0;
    repeat (4) tick();
    iSerial_end = 1'b1;
    tick();
    iSerial_end = 1'b0;
    repeat (2) tick();

    // Reuse of a held key skips the key window.
    push(S_LMSG, -1, 1, 0); push(S_ENC, 512, 1, 0);
    iStart = 1'b1; iReuse_key = 1'b1; iEn = 1'b1;
    tick();
    iStart = 1'b0;
    wait_state(S_ENC, 600);

    // iStart during ENCRYPT is ignored; simultaneous done+end goes straight to DONE,
    // and iStart held at DONE chains into the next job.
    iEn = 1'b0; iStart = 1'b1; iReuse_key = 1'b1;
    repeat (6) tick();
    push(S_DONE, -1, 1, 0); push(S_LMSG, 1, 1, 0);
    iEncrypt_done = 1'b1; iSerial_end = 1'b1;
    tick();
    iEncrypt_done = 1'b0; iSerial_end = 1'b0;
    tick();
    iStart = 1'b0;
    repeat (3) tick();

    // Abort during the message window keeps the key.
    push(S_IDLE, -1, 1, 0);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    tick();

    // Abort at key bit 10 with iStart also high: IDLE, key dropped.
    push(S_LKEY, -1, 1, 0); push(S_IDLE, 11, 0, 0);
    iStart = 1'b1; iReuse_key = 1'b0;
    tick();
    iStart = 1'b0; iEn = 1'b1;
    repeat (10) tick();
    iAbort = 1'b1; iStart = 1'b1;
    tick();
    iAbort = 1'b0; iStart = 1'b0; iEn = 1'b0;
    tick();

    // Reuse requested without a held key: full key window, iEn toggling 0/1 -> 64 cycles.
    push(S_LKEY, -1, 0, 0); push(S_LMSG, 64, 1, 0); push(S_ENC, 512, 1, 0);
    iStart = 1'b1; iReuse_key = 1'b1;
    tick();
    iStart = 1'b0;
    for (int k = 0; k < 64; k++) begin
      iEn = (k % 2) != 0;
      tick();
    end
    iEn = 1'b1;

`ifdef XOR_SEQ_TIMEOUT_EN
    // No encrypt completion: watchdog fires after 16 ENCRYPT cycles; abort clears it.
    push(S_ERR, 16, 1, 1);
    wait_state(S_ENC, 600);
    iEn = 1'b0;
    wait_state(S_ERR, 40);
    repeat (3) tick();
    push(S_IDLE, -1, 1, 0);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
`else
    // Without the watchdog, ENCRYPT waits indefinitely.
    push(S_SER, -1, 1, 0); push(S_DONE, 1, 1, 0); push(S_IDLE, 1, 1, 0);
    wait_state(S_ENC, 600);
    iEn = 1'b0;
    repeat (40) tick();
    iEncrypt_done = 1'b1;
    tick();
    iEncrypt_done = 1'b0; iSerial_end = 1'b1;
    tick();
    iSerial_end = 1'b0;
`endif

    repeat (5) tick();
    chk("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
